// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, requests words from the I-cache
// and queues returned instructions with their PCs for decode.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    output logic [XLEN-1:0]          INS_ADDR,
    output logic                     INS_READ_EN,
    input  logic [31:0]              INS_DATA,
    input  logic                     INS_BUSY_WAIT,
    input  logic                     REDIRECT_EN,
    input  logic [XLEN-1:0]          REDIRECT_PC,
    output logic                     OUT_VALID,
    output logic [31:0]              OUT_INSTR,
    output logic [XLEN-1:0]          OUT_PC,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // state   | meaning
    // ST_RUN  | normal fetch from r_fpc while the queue has room
    // ST_KILL | waiting out a miss to r_kpc whose data will be dropped
    typedef enum logic {ST_RUN, ST_KILL} state_t;

    state_t             r_state, w_state_nxt;
    logic [XLEN-1:0]    r_fpc, r_kpc;
    logic [AW-1:0]      r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic [31:0]        r_instr_q [DEPTH];
    logic [XLEN-1:0]    r_pc_q    [DEPTH];

    logic               w_read_en, w_capture, w_pop, w_outstanding;
    logic [XLEN-1:0]    w_addr;

    always_comb begin
        w_read_en   = 1'b0;
        w_addr      = r_fpc;
        w_capture   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                w_read_en = (r_count < CW'(DEPTH));
                w_capture = w_read_en && !INS_BUSY_WAIT;
            end
            ST_KILL: begin
                w_addr    = r_kpc;
                w_read_en = 1'b1;
                if (!INS_BUSY_WAIT) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
        w_outstanding = w_read_en && INS_BUSY_WAIT;
        // A redirect only needs to kill something if a miss is still pending.
        if (REDIRECT_EN) w_state_nxt = w_outstanding ? ST_KILL : ST_RUN;
    end

    assign INS_ADDR    = w_addr;
    assign INS_READ_EN = w_read_en && !RESET;
    assign OUT_VALID   = (r_count != '0) && !REDIRECT_EN && !RESET;
    assign OUT_INSTR   = r_instr_q[r_rd_ptr];
    assign OUT_PC      = r_pc_q[r_rd_ptr];
    assign COUNT       = RESET ? '0 : r_count;
    assign w_pop       = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fpc    <= RESET_PC;
            r_kpc    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (REDIRECT_EN) begin
            r_fpc    <= {REDIRECT_PC[XLEN-1:2], 2'b00};
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            if (r_state == ST_RUN && w_outstanding) r_kpc <= r_fpc;
        end else begin
            if (w_capture) begin
                r_fpc    <= r_fpc + XLEN'(4);
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && !REDIRECT_EN && w_capture) begin
            r_instr_q[r_wr_ptr] <= INS_DATA;
            r_pc_q[r_wr_ptr]    <= r_fpc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized and directed checks of fetch_queue_unit against a queue-based
// reference model of the fetch rules.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] INS_ADDR;
    logic        INS_READ_EN;
    logic [31:0] INS_DATA = '0;
    logic        INS_BUSY_WAIT = 1'b0;
    logic        REDIRECT_EN = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        OUT_VALID;
    logic [31:0] OUT_INSTR;
    logic [31:0] OUT_PC;
    logic        OUT_READY = 1'b0;
    logic [2:0]  COUNT;

    fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RESET(RESET),
        .INS_ADDR(INS_ADDR), .INS_READ_EN(INS_READ_EN),
        .INS_DATA(INS_DATA), .INS_BUSY_WAIT(INS_BUSY_WAIT),
        .REDIRECT_EN(REDIRECT_EN), .REDIRECT_PC(REDIRECT_PC),
        .OUT_VALID(OUT_VALID), .OUT_INSTR(OUT_INSTR), .OUT_PC(OUT_PC),
        .OUT_READY(OUT_READY), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_kpc;
    bit          m_killing;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc     = 32'h0;
        m_kpc     = 32'h0;
        m_killing = 1'b0;
    endtask

    // One cycle: drive on the falling edge, check, then advance the model at the rising edge.
    task automatic step(input bit rst, input bit busy, input logic [31:0] data,
                        input bit redir, input logic [31:0] rpc, input bit ready);
        bit          e_ren, e_valid;
        logic [31:0] e_addr;
        @(negedge CLK);
        RESET = rst; INS_BUSY_WAIT = busy; INS_DATA = data;
        REDIRECT_EN = redir; REDIRECT_PC = rpc; OUT_READY = ready;
        #1;
        if (rst) begin
            chk("rst_ren", 32'(INS_READ_EN), 32'd0);
            chk("rst_valid", 32'(OUT_VALID), 32'd0);
            chk("rst_count", 32'(COUNT), 32'd0);
            @(posedge CLK);
            model_reset();
            return;
        end
        e_ren   = m_killing || (m_q.size() < DEPTH);
        e_addr  = m_killing ? m_kpc : m_fpc;
        e_valid = (m_q.size() > 0) && !redir;
        chk("read_en", 32'(INS_READ_EN), 32'(e_ren));
        if (e_ren) chk("ins_addr", INS_ADDR, e_addr);
        chk("out_valid", 32'(OUT_VALID), 32'(e_valid));
        if (e_valid) begin
            chk("out_pc", OUT_PC, m_q[0].pc);
            chk("out_instr", OUT_INSTR, m_q[0].instr);
        end
        chk("count", 32'(COUNT), 32'(m_q.size()));
        @(posedge CLK);
        if (redir) begin
            if (e_ren && busy) begin
                if (!m_killing) m_kpc = e_addr;
                m_killing = 1'b1;
            end else begin
                m_killing = 1'b0;
            end
            m_q.delete();
            m_fpc = rpc & ~32'h3;
        end else if (m_killing) begin
            if (!busy) m_killing = 1'b0;
        end else begin
            if (e_valid && ready) void'(m_q.pop_front());
            if (e_ren && !busy) begin
                m_q.push_back('{instr: data, pc: m_fpc});
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic rand_phase(input int n, input int busy_pct, input int redir_pct, input int ready_pct);
        logic [31:0] rpc;
        for (int i = 0; i < n; i++) begin
            rpc = $urandom;
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            step(1'b0, $urandom_range(99) < busy_pct, $urandom, $urandom_range(99) < redir_pct,
                 rpc, $urandom_range(99) < ready_pct);
        end
    endtask

    initial begin
        model_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
        step(1'b1, 1'b1, 32'h0, 1'b1, 32'h80, 1'b1);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'hA000_0000 + i, 1'b0, '0, 1'b1);

        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'hB000_0000 + i, 1'b0, '0, 1'b0);
        #1;
        chk("full_count", 32'(COUNT), 32'd4);
        chk("full_ren", 32'(INS_READ_EN), 32'd0);
        step(1'b0, 1'b0, 32'hB100_0000, 1'b0, '0, 1'b1);
        #1;
        chk("after_pop_count", 32'(COUNT), 32'd3);
        chk("resume_addr", INS_ADDR, 32'h10);
        step(1'b0, 1'b0, 32'hB200_0000, 1'b0, '0, 1'b0);

        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 32'hC000_0000, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 32'hC000_0004, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom, 1'b0, '0, 1'b1);
        #1;
        chk("miss_hold_addr", INS_ADDR, 32'h8);
        step(1'b0, 1'b0, 32'hDEAD_0008, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 32'hC000_000C, 1'b0, '0, 1'b0);

        step(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hE000_0000 + i, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b1, 32'h200, 1'b1);
        step(1'b0, 1'b1, $urandom, 1'b1, 32'h300, 1'b1);
        #1;
        chk("kill_hold_addr", INS_ADDR, 32'hC);
        step(1'b0, 1'b1, $urandom, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 32'hBAD0_000C, 1'b0, '0, 1'b1);
        #1;
        chk("after_kill_addr", INS_ADDR, 32'h300);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hF000_0000 + i, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, $urandom, 1'b1, 32'h100, 1'b1);
        #1;
        chk("redir_count", 32'(COUNT), 32'd0);
        chk("redir_addr", INS_ADDR, 32'h100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h1100_0000 + i, 1'b0, '0, 1'b1);

        step(1'b0, 1'b0, $urandom, 1'b1, 32'h203, 1'b1);
        #1;
        chk("align_addr", INS_ADDR, 32'h200);
        step(1'b0, 1'b0, 32'h2200_0000, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, $urandom, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'h3300_0000, 1'b0, '0, 1'b1);
        #1;
        chk("wrap_addr", INS_ADDR, 32'h0);
        step(1'b0, 1'b0, 32'h3300_0004, 1'b0, '0, 1'b1);

        rand_phase(1500, 30, 5, 70);
        rand_phase(800, 70, 10, 30);
        step(1'b0, 1'b1, $urandom, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, $urandom, 1'b1, 32'h44, 1'b0);
        rand_phase(1500, 10, 3, 90);
        rand_phase(800, 50, 20, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
